// File: rtl/ex_shift_pipe_if.sv
// ex_shift_pipe_if: groups the ID/EX input bus, the EX/MEM result bus and the
// flush line of the two-stage shift unit. The slave modport is the unit's view.
// The master modport is the view of the surrounding pipeline.
interface ex_shift_pipe_if;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_op;
   logic [31:0] i_rs;
   logic [4:0]  i_amount;
   logic [4:0]  i_rd_addr;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_result;
   logic [4:0]  o_rd_addr;

   modport slave (
      input  i_valid, i_op, i_rs, i_amount, i_rd_addr, i_flush, i_ready,
      output o_ready, o_valid, o_result, o_rd_addr
   );

   modport master (
      output i_valid, i_op, i_rs, i_amount, i_rd_addr, i_flush, i_ready,
      input  o_ready, o_valid, o_result, o_rd_addr
   );
endinterface

// File: rtl/ex_shift_pipe.sv
// ex_shift_pipe: two-stage pipelined shift/rotate unit for the EX stage.
// Stage 1 applies the coarse shift levels (16, 8).
// Stage 2 applies the fine levels (4, 2, 1) and holds the registered output.
// Optional macro SHIFT_ROTATE_EN adds ROL (011) and ROR (100). Without it those
// codes are reserved and yield a zero result.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Upstream transfers when bus.i_valid & bus.o_ready. Downstream transfers
// when bus.o_valid & bus.i_ready. o_ready looks ahead through i_ready, so a full
// pipe can drain and refill in the same edge. A flush blocks the input and kills
// both stages at the next edge.
module ex_shift_pipe (
   input  logic           i_clk,
   input  logic           i_reset,
   ex_shift_pipe_if.slave bus
);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
`ifdef SHIFT_ROTATE_EN
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;
`endif

   // Applies one shift level of n positions when en is set.
   // Reserved ops collapse to zero, so their result reaches the output as 0.
   // SRA fills from bit 31 of d. That bit still equals the original sign at
   // every level.
   function automatic logic [31:0] shift_level(input logic [31:0] d,
                                                input logic [2:0]  op,
                                                input logic        en,
                                                input int unsigned n);
      logic [31:0] r;
      r = d;
      case (op)
         OP_SLL: if (en) r = d << n;
         OP_SRL: if (en) r = d >> n;
         OP_SRA: if (en) r = $signed(d) >>> n;
`ifdef SHIFT_ROTATE_EN
         OP_ROL: if (en) r = (d << n) | (d >> (32 - n));
         OP_ROR: if (en) r = (d >> n) | (d << (32 - n));
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   logic        s1_valid;
   logic [2:0]  s1_op;
   logic [2:0]  s1_amount;
   logic [4:0]  s1_rd_addr;
   logic [31:0] s1_data;

   logic        s2_valid;
   logic [31:0] s2_result;
   logic [4:0]  s2_rd_addr;

   logic        s1_adv;
   logic        accept;
   logic [31:0] s1_lvl16;
   logic [31:0] s1_next;
   logic [31:0] s2_lvl4;
   logic [31:0] s2_lvl2;
   logic [31:0] s2_next;

   // Handshake terms: stage 1 moves on when stage 2 is empty or draining.
   always_comb begin
      s1_adv      = s1_valid & (!s2_valid | bus.i_ready);
      bus.o_ready = !bus.i_flush & (!s1_valid | s1_adv);
      accept      = bus.i_valid & bus.o_ready;
   end

   // Coarse shift datapath feeding the stage 1 register.
   always_comb begin
      s1_lvl16 = shift_level(bus.i_rs, bus.i_op, bus.i_amount[4], 16);
      s1_next  = shift_level(s1_lvl16, bus.i_op, bus.i_amount[3], 8);
   end

   // Fine shift datapath feeding the stage 2 register.
   always_comb begin
      s2_lvl4 = shift_level(s1_data, s1_op, s1_amount[2], 4);
      s2_lvl2 = shift_level(s2_lvl4, s1_op, s1_amount[1], 2);
      s2_next = shift_level(s2_lvl2, s1_op, s1_amount[0], 1);
   end

   // Stage 1 register: loads on accept, empties when it advances without refill.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s1_valid   <= 1'b0;
         s1_op      <= '0;
         s1_amount  <= '0;
         s1_rd_addr <= '0;
         s1_data    <= '0;
      end else if (bus.i_flush) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid   <= 1'b1;
         s1_op      <= bus.i_op;
         s1_amount  <= bus.i_amount[2:0];
         s1_rd_addr <= bus.i_rd_addr;
         s1_data    <= s1_next;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2 register: loads on advance and holds steady while the output stalls.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s2_valid   <= 1'b0;
         s2_result  <= '0;
         s2_rd_addr <= '0;
      end else if (bus.i_flush) begin
         s2_valid <= 1'b0;
      end else if (s1_adv) begin
         s2_valid   <= 1'b1;
         s2_result  <= s2_next;
         s2_rd_addr <= s1_rd_addr;
      end else if (bus.i_ready) begin
         s2_valid <= 1'b0;
      end
   end

   // Registered outputs come straight from stage 2.
   always_comb begin
      bus.o_valid   = s2_valid;
      bus.o_result  = s2_result;
      bus.o_rd_addr = s2_rd_addr;
   end

endmodule

// File: doc/ex_shift_pipe.md
# ex_shift_pipe

Two-stage pipelined shift execution unit for the EX stage of the RISC-V core. It accepts a shift operation, a 32-bit operand and a 5-bit shift amount from the ID/EX side, then delivers the result and destination tag to the EX/MEM side. Operands, results and tags move through the stages under valid/ready handshakes. Stage 1 applies the coarse shift levels (16, 8); stage 2 applies the fine levels (4, 2, 1) and drives the registered output.

## Interface
- No parameters; data width is fixed at 32 and the amount width at 5.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  reset, synchronous and active-high.
- i_valid  input  1  an operation is presented.
- o_ready  output  1  the unit accepts the operation this cycle.
- i_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; all other codes are reserved.
- i_rs  input  32  operand.
- i_amount  input  5  shift amount; only bits [4:0] are used.
- i_rd_addr  input  5  destination register tag, carried alongside the data.
- i_flush  input  1  kills every in-flight operation.
- o_valid  output  1  o_result and o_rd_addr hold a result.
- i_ready  input  1  the downstream stage accepts the result.
- o_result  output  32  shift result.
- o_rd_addr  output  5  tag of the result.

## Operation
- **Transfer rule.** A transfer occurs at an edge where valid and ready are both high.
- **Input handshake.**
  - Input accept = i_valid & o_ready.
  - o_ready = !i_flush & (!s1_valid | s1_adv).
  - s1_adv = s1_valid & (!s2_valid | i_ready).
  - o_ready depends combinationally on i_ready.
- **Stage 1, on accept.**
  - Register op, tag and the remaining amount[2:0].
  - Register the partial result after applying amount[4] (16 positions) and amount[3] (8 positions).
  - Set s1_valid.
  - If s1 advances and nothing is accepted, clear s1_valid.
- **Stage 2, on s1_adv.**
  - Register the final result after applying amount[2], amount[1] and amount[0].
  - Copy the tag and set s2_valid (= o_valid).
  - If i_ready is high and there is no s1_adv, clear s2_valid.
- **Holding.** Data registers load only on accept or advance; otherwise they hold. While o_valid is high and i_ready is low, o_result and o_rd_addr stay stable.
- **Shift semantics per level.**
  - SRL: zero fill on the left.
  - SRA: fill with bit 31 of the current level's value, i.e. the sign of the original operand.
  - SLL: zero fill on the right.
  - ROL/ROR: bits shifted out re-enter at the opposite end.
  - Amount 0 passes i_rs unchanged for every legal op.
- **Reserved op codes.** The operation is carried through the pipeline normally with o_result = 0.
- **Flush.**
  - i_flush high clears s1_valid and s2_valid at the next edge, regardless of i_ready.
  - No accept happens in the flush cycle.
  - Data registers are don't-care after a flush.
- **Reset.**
  - i_reset has priority over everything else.
  - At the edge it forces s1_valid = 0 and o_valid = 0, o_result = 0, o_rd_addr = 0, and clears the stage 1 registers to 0.
  - An in-flight operation is discarded; there is no partial output.

## Timing
- Latency is 2 cycles: accepted at edge N, o_valid is high after edge N+1.
- Throughput is 1 operation per cycle when i_ready is held high.
- Stall behaviour:
  - Both stages full and i_ready low: o_ready = 0.
  - i_ready rising releases s2 and s1 in the same edge, and a new input is accepted in that edge.
- Results leave in acceptance order; no reordering and no drops.
- Simultaneous events:
  - i_flush together with i_ready: the flush wins and no result is counted as transferred.
  - i_flush together with i_valid: the input is not accepted.
- Critical path: stage 1 is 2 mux levels and stage 2 is 3 mux levels.

## Configuration
- **SHIFT_ROTATE_EN**
  - Defined: op codes 011 (ROL) and 100 (ROR) are implemented with wrap-around at every level.
  - Undefined: 011 and 100 are reserved and yield o_result = 0, and the rotate logic is absent.
  - The handshake, latency and tag path are identical in both builds.

## Test plan
- SRA, i_rs = 0x80000000, amount 31, i_ready high -> o_valid after 2 edges with o_result = 0xFFFFFFFF; SRL with the same operands -> 0x00000001.
- SLL, i_rs = 0x00000001, amount 31 -> 0x80000000; SLL 0xDEADBEEF amount 0 -> 0xDEADBEEF.
- Three back-to-back ops with tags 1, 2, 3 while i_ready is held low for 3 cycles:
  - o_ready drops to 0 once both stages are full;
  - o_result is stable during the stall;
  - on release, tags appear in order 1, 2, 3 with no loss.
- i_flush pulsed while both stages are valid -> o_valid = 0 next cycle, o_ready = 0 during the pulse, and a subsequent op completes normally.
- i_reset asserted one cycle after accepting an op -> o_valid, o_result and o_rd_addr are all 0 after the edge, and the dropped op never appears.
- ROR, i_rs = 0x12345678, amount 8:
  - with SHIFT_ROTATE_EN -> 0x78123456;
  - ROL amount 4 -> 0x23456781;
  - without the macro -> 0x00000000 for both.
